product_accumulator: RTL and testbench

Downstream consumer of the unsigned shift-add multiplier. Accepts one 16-bit product per valid/ready handshake, sums a fixed number of products per frame into a wider saturating accumulator, and presents the frame sum with an overflow flag on a valid/ready output port. Together with the multiplier it forms a multiply-accumulate path for dot products of 8-bit vectors.

---
 rtl/product_accumulator.sv | 114 +++++++++++
 tb/tb_product_accumulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator
//  Description : Sums FRAME_LEN unsigned products per frame into a saturating
//                AW-bit accumulator and presents the frame sum and an overflow
//                flag on a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int PW        = 16,
    parameter int AW        = 24,
    parameter int FRAME_LEN = 8
) (
    input  logic          sclk,
    input  logic          s_rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [AW-1:0] acc_data,
    output logic          acc_ovf,
    output logic [7:0]    frame_idx
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index of the transfer that closes a frame.
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t          state_q;
    logic [AW-1:0]   acc_q;
    logic            ovf_q;
    logic [7:0]      idx_q;
    logic            valid_q;
    logic [AW-1:0]   data_q;
    logic            dovf_q;

    logic [AW:0]     sum_d;
    logic [AW-1:0]   acc_d;
    logic            ovf_d;

    // Candidate accumulator value for a transfer this cycle; one guard bit
    // catches carry-out, and once the sticky flag is set the sum is pinned
    // at full scale for the rest of the frame.
    always_comb begin
        sum_d = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, in_data};
        ovf_d = sum_d[AW] | ovf_q;
        acc_d = ovf_d ? {AW{1'b1}} : sum_d[AW-1:0];
    end

    // Frame state machine: accumulate, latch the result, hold until taken.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dovf_q  <= 1'b0;
        end else if (clr) begin
            // Flush: partial sum and any pending result are discarded,
            // while the last presented data value is left in place.
            state_q <= ST_ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        if (idx_q == LAST_IDX) begin
                            data_q  <= acc_d;
                            dovf_q  <= ovf_d;
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                            acc_q   <= '0;
                            ovf_q   <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            acc_q   <= acc_d;
                            ovf_q   <= ovf_d;
                            idx_q   <= idx_q + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (acc_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_ACC;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    // Upstream is accepted only while accumulating; pure decode of state.
    assign in_ready  = (state_q == ST_ACC);
    assign acc_valid = valid_q;
    assign acc_data  = data_q;
    assign acc_ovf   = dovf_q;
    assign frame_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_accumulator
//  Description : Scoreboard bench for product_accumulator (FRAME_LEN=4,
//                AW=17) with directed boundary frames and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    localparam int PW  = 16;
    localparam int AW  = 17;
    localparam int FL  = 4;
    localparam longint MAXV = (longint'(1) << AW) - 1;

    logic          sclk = 1'b0;
    logic          s_rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          acc_valid;
    logic          acc_ready;
    logic [AW-1:0] acc_data;
    logic          acc_ovf;
    logic [7:0]    frame_idx;

    product_accumulator #(.PW(PW), .AW(AW), .FRAME_LEN(FL)) dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .acc_ovf   (acc_ovf),
        .frame_idx (frame_idx)
    );

    always #5 sclk = ~sclk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model state: transaction-level view of a frame.
    longint      m_sum  = 0;
    int          m_cnt  = 0;
    bit          m_hold = 1'b0;
    longint      m_last = 0;
    logic [AW:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: tracks the true frame sum with plain arithmetic and predicts
    // the saturated result once FL products have been taken.
    initial begin
        forever begin
            @(posedge sclk);
            if (!s_rst_n) begin
                m_sum = 0; m_cnt = 0; m_hold = 1'b0; m_last = 0;
            end else if (clr) begin
                m_sum = 0; m_cnt = 0; m_hold = 1'b0;
            end else if (!m_hold) begin
                if (in_valid) begin
                    m_sum = m_sum + longint'(in_data);
                    m_cnt++;
                    if (m_cnt == FL) begin
                        m_last = (m_sum > MAXV) ? MAXV : m_sum;
                        exp_q.push_back({(m_sum > MAXV), AW'(m_last)});
                        m_sum = 0; m_cnt = 0; m_hold = 1'b1;
                    end
                end
            end else if (acc_ready) begin
                m_hold = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires scoreboard entries
    // on delivery (valid && ready) or drop (clr / reset while valid).
    initial begin
        forever begin
            @(negedge sclk);
            if (mon_en) begin
                chk("in_ready", in_ready, !m_hold);
                chk("acc_valid", acc_valid, m_hold);
                chk("frame_idx", frame_idx, m_cnt);
                if (acc_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        chk("acc_data", acc_data, exp_q[0][AW-1:0]);
                        chk("acc_ovf", acc_ovf, exp_q[0][AW]);
                        if (!s_rst_n || clr || acc_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("acc_data_idle", acc_data, m_last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // Offer one product and wait (bounded) until it is accepted.
    task automatic send(input logic [PW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("send_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
        in_data  = PW'($urandom);
    endtask

    task automatic frame(input logic [PW-1:0] a, input logic [PW-1:0] b,
                         input logic [PW-1:0] c, input logic [PW-1:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_acc_valid"}, acc_valid, 0);
        chk({tag, "_acc_data"},  acc_data, 0);
        chk({tag, "_acc_ovf"},   acc_ovf, 0);
        chk({tag, "_frame_idx"}, frame_idx, 0);
        chk({tag, "_in_ready"},  in_ready, 1);
    endtask

    initial begin
        s_rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; acc_ready = 1'b1;
        repeat (2) tick();
        s_rst_n = 1'b1;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Basic, exact full-scale, saturation, sticky clearing, late saturation.
        frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        tick();
        frame(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);
        tick();
        frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        tick();
        frame(16'h0001, 16'h0001, 16'h0001, 16'h0001);
        tick();
        frame(16'hFFFF, 16'hFFFF, 16'h0002, 16'h0001);
        tick();

        // Backpressure: result held 5 cycles, then accepted.
        acc_ready = 1'b0;
        frame(16'h1234, 16'h0101, 16'h0042, 16'h0007);
        repeat (5) tick();
        acc_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", in_ready, 1);

        // Flush mid-frame with a concurrent valid product.
        send(16'h0010); send(16'h0020);
        in_valid = 1'b1; in_data = 16'h0030; clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_mid_idx", frame_idx, 0);
        chk("clr_mid_valid", acc_valid, 0);
        frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        tick();

        // Flush coinciding with the last-of-frame transfer.
        send(16'h0100); send(16'h0200); send(16'h0300);
        in_valid = 1'b1; in_data = 16'h0400; clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_last_valid", acc_valid, 0);
        chk("clr_last_idx", frame_idx, 0);

        // Flush in HOLD together with acc_ready: result dropped.
        acc_ready = 1'b0;
        frame(16'h0005, 16'h0006, 16'h0007, 16'h0008);
        clr = 1'b1; acc_ready = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hold_valid", acc_valid, 0);

        // Reset mid-frame and in HOLD.
        send(16'h0055); send(16'h0066);
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
        check_reset_outputs("rst_mid");
        acc_ready = 1'b0;
        frame(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1; acc_ready = 1'b1;
        check_reset_outputs("rst_hold");

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            case ($urandom_range(3))
                0:       in_data = 16'hFFFF;
                1:       in_data = PW'($urandom_range(15));
                default: in_data = PW'($urandom);
            endcase
            acc_ready = ($urandom_range(2) != 0);
            clr       = ($urandom_range(49) == 0);
            s_rst_n   = ($urandom_range(199) != 0);
            tick();
        end

        in_valid = 1'b0; clr = 1'b0; s_rst_n = 1'b1; acc_ready = 1'b1;
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
